stall_data_memory_responder: RTL and testbench

- Responder (memory) end of the core's data bus handshake: address, read_enable, write_enable, byte_enable, write_data in; wait_req, valid, read_data out.
- Word-addressed synchronous RAM window with programmable wait states and read latency.
- Supports one outstanding read at a time.
- Drop-in alternative to the example data memory in the pipeline toplevel, used to stress core stall and valid handling.

---
 rtl/stall_data_memory_responder.sv | 142 ++++++++++++++
 tb/tb_stall_data_memory_responder.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/stall_data_memory_responder.sv
// Word-addressed RAM responder for the core data bus with programmable wait states and read latency.
// Optional pseudo-random extra stalls when STALL_DATA_MEMORY_RANDOM_STALL_EN is defined.
module stall_data_memory_responder #(
    parameter int unsigned DEPTH_WORDS  = 1024,
    parameter logic [31:0] BASE_ADDR    = 32'h0000_0000,
    parameter int unsigned WAIT_STATES  = 2,
    parameter int unsigned READ_LATENCY = 1
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] address,
    input  logic        read_enable,
    input  logic        write_enable,
    input  logic [3:0]  byte_enable,
    input  logic [31:0] write_data,
    output logic        wait_req,
    output logic        valid,
    output logic [31:0] read_data
);
    localparam int AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam logic [32:0] END_ADDR = {1'b0, BASE_ADDR} + 33'(DEPTH_WORDS) * 33'd4;
    localparam logic [2:0]  LAT_INIT = 3'(READ_LATENCY - 1);

    typedef enum logic [1:0] {IDLE, STALL, PEND} state_t;

    state_t         state_q, state_d;
    logic [4:0]     ws_q, ws_d;
    logic [2:0]     lat_q, lat_d;
    logic           valid_q, valid_d;
    logic [31:0]    rd_q, rd_d;
    logic [31:0]    cap_q;
    logic [3:0][7:0] mem_q [DEPTH_WORDS];

    logic           req, hit, accept, wr_acc, rd_acc;
    logic [31:0]    offs;
    logic [AW-1:0]  idx;
    logic [4:0]     ws_load;

    assign req  = read_enable | write_enable;
    assign hit  = ({1'b0, address} >= {1'b0, BASE_ADDR}) && ({1'b0, address} < END_ADDR);
    assign offs = address - BASE_ADDR;
    assign idx  = AW'(offs >> 2);

`ifdef STALL_DATA_MEMORY_RANDOM_STALL_EN
    logic [15:0] lfsr_q;

    // Fibonacci form of x^16+x^14+x^13+x^11+1, shifting toward bit 0
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) lfsr_q <= 16'hACE1;
        else        lfsr_q <= {lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5], lfsr_q[15:1]};
    end

    assign ws_load = 5'(WAIT_STATES) + {3'b000, lfsr_q[1:0]};
`else
    assign ws_load = 5'(WAIT_STATES);
`endif

    always_comb begin
        state_d  = state_q;
        ws_d     = ws_q;
        lat_d    = lat_q;
        valid_d  = 1'b0;
        rd_d     = rd_q;
        wait_req = 1'b0;
        accept   = 1'b0;
        case (state_q)
            IDLE: begin
                if (req) begin
                    if (ws_load == 5'd0) begin
                        accept = 1'b1;
                    end else begin
                        // The IDLE cycle itself counts as the first wait cycle
                        wait_req = 1'b1;
                        ws_d     = ws_load - 5'd1;
                        state_d  = STALL;
                    end
                end
            end
            STALL: begin
                if (ws_q != 5'd0) begin
                    wait_req = 1'b1;
                    ws_d     = ws_q - 5'd1;
                end else if (req) begin
                    accept = 1'b1;
                end else begin
                    state_d = IDLE;
                end
            end
            PEND: begin
                wait_req = 1'b1;
                if (lat_q == 3'd0) begin
                    valid_d = 1'b1;
                    rd_d    = cap_q;
                    state_d = IDLE;
                end else begin
                    lat_d = lat_q - 3'd1;
                end
            end
            default: state_d = IDLE;
        endcase
        if (accept) begin
            if (write_enable) begin
                state_d = IDLE;
            end else begin
                lat_d   = LAT_INIT;
                state_d = PEND;
            end
        end
    end

    assign wr_acc = accept & write_enable & hit;
    assign rd_acc = accept & ~write_enable;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            ws_q    <= '0;
            lat_q   <= '0;
            valid_q <= 1'b0;
            rd_q    <= '0;
        end else begin
            state_q <= state_d;
            ws_q    <= ws_d;
            lat_q   <= lat_d;
            valid_q <= valid_d;
            rd_q    <= rd_d;
        end
    end

    // RAM array and its read capture register are deliberately not reset
    always_ff @(posedge clock) begin
        if (wr_acc) begin
            for (int b = 0; b < 4; b++) begin
                if (byte_enable[b]) mem_q[idx][b] <= write_data[8*b +: 8];
            end
        end
        if (rd_acc) cap_q <= hit ? mem_q[idx] : 32'h0;
    end

    assign valid     = valid_q;
    assign read_data = rd_q;
endmodule

// File: tb/tb_stall_data_memory_responder.sv
// Bench for stall_data_memory_responder: directed table, hand sequences and randomized traffic
// checked against a word-array model on two configurations.
module tb_stall_data_memory_responder;
    logic        clk;
    logic        rst_n;
    logic [31:0] addr [2];
    logic        re [2];
    logic        we [2];
    logic [3:0]  be [2];
    logic [31:0] wd [2];
    logic        w_req [2];
    logic        vld [2];
    logic [31:0] rdat [2];

    int nvec = 0;
    int nerr = 0;

    stall_data_memory_responder u0 (
        .clock(clk), .reset(rst_n), .address(addr[0]), .read_enable(re[0]),
        .write_enable(we[0]), .byte_enable(be[0]), .write_data(wd[0]),
        .wait_req(w_req[0]), .valid(vld[0]), .read_data(rdat[0]));

    stall_data_memory_responder #(
        .DEPTH_WORDS(16), .BASE_ADDR(32'hFFFF_FFC0), .WAIT_STATES(0), .READ_LATENCY(3)
    ) u1 (
        .clock(clk), .reset(rst_n), .address(addr[1]), .read_enable(re[1]),
        .write_enable(we[1]), .byte_enable(be[1]), .write_data(wd[1]),
        .wait_req(w_req[1]), .valid(vld[1]), .read_data(rdat[1]));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int     ws_p [2]    = '{2, 0};
    int     rl_p [2]    = '{1, 3};
    longint depth_p [2] = '{1024, 16};
    longint base_p [2]  = '{64'h0, 64'hFFFF_FFC0};

    logic [31:0] mdl [longint];
    logic [31:0] last_rd [2];
    logic [15:0] lfsr_m;

    // Reference sequence of the spec's stall LFSR, stepped once per clock out of reset
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) lfsr_m <= 16'hACE1;
        else        lfsr_m <= 16'((lfsr_m >> 1) | (((lfsr_m ^ (lfsr_m >> 2) ^ (lfsr_m >> 3) ^ (lfsr_m >> 5)) & 16'h1) << 15));
    end

    function automatic bit m_hit(input int i, input logic [31:0] a);
        longint la = longint'(a);
        return (la >= base_p[i]) && (la < base_p[i] + 4 * depth_p[i]);
    endfunction

    function automatic longint m_key(input int i, input logic [31:0] a);
        return longint'(i) * 100000 + (longint'(a) - base_p[i]) / 4;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    task automatic txn(input int i, input bit w, input bit r, input logic [31:0] a,
                       input logic [3:0] b, input logic [31:0] d,
                       input bit use_exp, input logic [31:0] exp_tab);
        int          waits = 0;
        int          ext = 0;
        int          pend = 0;
        int          pwr = 0;
        logic [31:0] exp_rd = 32'h0;
        bit          is_rd = r && !w;
        @(posedge clk); #1;
        we[i] = w; re[i] = r; addr[i] = a; be[i] = b; wd[i] = d;
        forever begin
            @(negedge clk);
`ifdef STALL_DATA_MEMORY_RANDOM_STALL_EN
            if (waits == 0) ext = int'(lfsr_m[1:0]);
`endif
            if (!w_req[i]) break;
            waits++;
            if (waits > 40) begin chk("accept_timeout", 32'd1, 32'd0); break; end
        end
        @(posedge clk); #1;
        we[i] = 1'b0; re[i] = 1'b0;
        chk("wait_cycles", waits, ws_p[i] + ext);
        if (w) begin
            if (m_hit(i, a)) begin
                logic [31:0] old = mdl.exists(m_key(i, a)) ? mdl[m_key(i, a)] : 32'h0;
                for (int k = 0; k < 4; k++) if (b[k]) old[8*k +: 8] = d[8*k +: 8];
                mdl[m_key(i, a)] = old;
            end
        end else if (m_hit(i, a)) begin
            exp_rd = mdl[m_key(i, a)];
        end
        if (use_exp) exp_rd = exp_tab;
        if (is_rd) begin
            forever begin
                @(negedge clk);
                if (vld[i]) break;
                pend++;
                pwr += int'(w_req[i]);
                if (pend > 20) begin chk("valid_timeout", 32'd1, 32'd0); break; end
            end
            chk("read_latency", pend, rl_p[i]);
            chk("pend_wait_req", pwr, rl_p[i]);
            chk("read_data", rdat[i], exp_rd);
            last_rd[i] = exp_rd;
            @(negedge clk);
            chk("valid_pulse_len", {31'b0, vld[i]}, 32'd0);
        end else begin
            @(negedge clk);
            chk("write_no_valid", {31'b0, vld[i]}, 32'd0);
            chk("read_data_hold", rdat[i], last_rd[i]);
        end
    endtask

    typedef struct {
        int          inst;
        bit          w;
        bit          r;
        logic [31:0] a;
        logic [3:0]  b;
        logic [31:0] d;
        logic [31:0] exp;
    } vec_t;

    vec_t tab [21];

    logic [31:0] pool0 [7] = '{32'h0, 32'h4, 32'h10, 32'h20, 32'h100, 32'hFF8, 32'hFFC};
    logic [31:0] miss0 [3] = '{32'h1000, 32'h2000, 32'hFFFF_FFFC};
    logic [31:0] miss1 [3] = '{32'h0, 32'hFFFF_FFBC, 32'h40};

    initial begin
        tab[0]  = '{0, 1, 0, 32'h10,        4'hF, 32'hDEADBEEF, 32'h0};
        tab[1]  = '{0, 0, 1, 32'h10,        4'h0, 32'h0,        32'hDEADBEEF};
        tab[2]  = '{0, 1, 0, 32'h20,        4'hF, 32'h11223344, 32'h0};
        tab[3]  = '{0, 1, 0, 32'h20,        4'h5, 32'hAABBCCDD, 32'h0};
        tab[4]  = '{0, 0, 1, 32'h20,        4'h0, 32'h0,        32'h11BB33DD};
        tab[5]  = '{0, 1, 0, 32'h0,         4'hF, 32'hCAFEF00D, 32'h0};
        tab[6]  = '{0, 0, 1, 32'h1000,      4'h0, 32'h0,        32'h0};
        tab[7]  = '{0, 1, 0, 32'h1000,      4'hF, 32'h12345678, 32'h0};
        tab[8]  = '{0, 0, 1, 32'h0,         4'h0, 32'h0,        32'hCAFEF00D};
        tab[9]  = '{0, 1, 1, 32'hFFC,       4'hF, 32'h0BADC0DE, 32'h0};
        tab[10] = '{0, 0, 1, 32'hFFC,       4'h0, 32'h0,        32'h0BADC0DE};
        tab[11] = '{0, 1, 0, 32'h20,        4'h0, 32'hFFFFFFFF, 32'h0};
        tab[12] = '{0, 0, 1, 32'h23,        4'h0, 32'h0,        32'h11BB33DD};
        tab[13] = '{1, 1, 0, 32'hFFFF_FFFC, 4'hF, 32'h5A5A5A5A, 32'h0};
        tab[14] = '{1, 0, 1, 32'hFFFF_FFFC, 4'h0, 32'h0,        32'h5A5A5A5A};
        tab[15] = '{1, 1, 0, 32'hFFFF_FFC0, 4'hF, 32'h01020304, 32'h0};
        tab[16] = '{1, 1, 0, 32'h0,         4'hF, 32'h77777777, 32'h0};
        tab[17] = '{1, 0, 1, 32'hFFFF_FFC0, 4'h0, 32'h0,        32'h01020304};
        tab[18] = '{1, 0, 1, 32'h0,         4'h0, 32'h0,        32'h0};
        tab[19] = '{1, 0, 1, 32'hFFFF_FFBC, 4'h0, 32'h0,        32'h0};
        tab[20] = '{1, 0, 1, 32'h40,        4'h0, 32'h0,        32'h0};

        for (int i = 0; i < 2; i++) begin
            addr[i] = '0; re[i] = 1'b0; we[i] = 1'b0; be[i] = '0; wd[i] = '0; last_rd[i] = '0;
        end
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            chk("reset_wait_req", {31'b0, w_req[i]}, 32'd0);
            chk("reset_valid", {31'b0, vld[i]}, 32'd0);
            chk("reset_read_data", rdat[i], 32'd0);
        end

        // Directed vectors
        for (int v = 0; v < 21; v++)
            txn(tab[v].inst, tab[v].w, tab[v].r, tab[v].a, tab[v].b, tab[v].d,
                tab[v].r && !tab[v].w, tab[v].exp);

`ifndef STALL_DATA_MEMORY_RANDOM_STALL_EN
        // Back-to-back reads on the zero-wait, latency-3 instance
        @(posedge clk); #1;
        re[1] = 1'b1; addr[1] = 32'hFFFF_FFFC;
        @(negedge clk);
        chk("b2b_first_no_stall", {31'b0, w_req[1]}, 32'd0);
        @(posedge clk); #1;
        addr[1] = 32'hFFFF_FFC0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("b2b_pend1", {30'b0, w_req[1], vld[1]}, 32'd2);
        end
        @(negedge clk);
        chk("b2b_valid1", {30'b0, w_req[1], vld[1]}, 32'd1);
        chk("b2b_data1", rdat[1], 32'h5A5A5A5A);
        @(posedge clk); #1;
        re[1] = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("b2b_pend2", {30'b0, w_req[1], vld[1]}, 32'd2);
        end
        @(negedge clk);
        chk("b2b_valid2", {31'b0, vld[1]}, 32'd1);
        chk("b2b_data2", rdat[1], 32'h01020304);
        last_rd[1] = 32'h01020304;
`endif

        // Preload every word the random phase can read
        for (int k = 0; k < 7; k++) txn(0, 1, 0, pool0[k], 4'hF, $urandom, 0, 32'h0);
        for (int k = 0; k < 16; k++) txn(1, 1, 0, 32'hFFFF_FFC0 + 32'(4 * k), 4'hF, $urandom, 0, 32'h0);

        for (int n = 0; n < 80; n++) begin
            int          i = int'($urandom_range(0, 1));
            int          kind = int'($urandom_range(0, 4));
            logic [31:0] a;
            if ($urandom_range(0, 9) < 2)
                a = (i == 0) ? miss0[$urandom_range(0, 2)] : miss1[$urandom_range(0, 2)];
            else
                a = (i == 0) ? pool0[$urandom_range(0, 6)] : 32'hFFFF_FFC0 + 32'(4 * $urandom_range(0, 15));
            a = a | 32'($urandom_range(0, 3));
            txn(i, kind >= 3, kind != 3, a, 4'($urandom), $urandom, 0, 32'h0);
        end

        // Reset while a latency-3 read is pending
        @(posedge clk); #1;
        re[1] = 1'b1; addr[1] = 32'hFFFF_FFC0;
        begin
            int guard = 0;
            forever begin
                @(negedge clk);
                if (!w_req[1]) break;
                guard++;
                if (guard > 40) begin chk("rst_accept_timeout", 32'd1, 32'd0); break; end
            end
        end
        @(posedge clk); #1;
        re[1] = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        begin
            int seen = 0;
            for (int k = 0; k < 8; k++) begin
                @(negedge clk);
                seen += int'(vld[1]) + int'(vld[0]);
            end
            chk("rst_no_valid", seen, 32'd0);
        end
        chk("rst_wait_req", {31'b0, w_req[1]}, 32'd0);
        chk("rst_read_data", rdat[1], 32'd0);
        last_rd[0] = '0;
        last_rd[1] = '0;

        // Traffic after reset: RAM contents survive, LFSR restarts from its seed
        txn(1, 0, 1, 32'hFFFF_FFC0, 4'h0, 32'h0, 0, 32'h0);
        txn(0, 0, 1, 32'h10, 4'h0, 32'h0, 0, 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got running, expected finished");
        $fatal(1, "bench timeout");
    end
endmodule
